i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 163 ++++++++++++++++
 tb/tb_i2c_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// i2c_arbiter: shares one I2C master between two requesters.
// Round-robin selection in IDLE, bus lock between START and STOP,
// and forced release of an idle locked owner after TIMEOUT_CYC cycles.
module i2c_arbiter #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic [3:0] m0_cmd,
    input  logic [7:0] m0_wr_data,
    output logic [7:0] m0_rd_data,
    output logic       m0_done,
    output logic       m0_ack,
    output logic       m0_grant,
    input  logic       m1_req,
    input  logic [3:0] m1_cmd,
    input  logic [7:0] m1_wr_data,
    output logic [7:0] m1_rd_data,
    output logic       m1_done,
    output logic       m1_ack,
    output logic       m1_grant,
    output logic       i2c_req,
    output logic [3:0] i2c_cmd,
    output logic [7:0] i2c_wr_data,
    input  logic [7:0] i2c_rd_data,
    input  logic       i2c_done,
    input  logic       i2c_slave_ack,
    output logic       busy,
    output logic       timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // Compare one below the final count so the registered timeout pulse
    // appears in the same cycle the counter shows TIMEOUT_CYC-1.
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYC - 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE,
        ST_OWN
    } state_t;

    state_t           state;
    logic             owner;      // 0 = m0, 1 = m1
    logic             rr_next;    // requester preferred on a tie
    logic [CNT_W-1:0] idle_cnt;

    logic             idle_pick;
    logic             sel;
    logic             owner_req;
    logic [3:0]       sel_cmd;
    logic [7:0]       sel_wr;

    // Requester selection and the command/data of the selected requester
    always_comb begin
        idle_pick = rr_next;
        if (m0_req && !m1_req) begin
            idle_pick = 1'b0;
        end else if (m1_req && !m0_req) begin
            idle_pick = 1'b1;
        end
        sel       = (state == ST_OWN) ? owner : idle_pick;
        owner_req = owner ? m1_req : m0_req;
        sel_cmd   = sel ? m1_cmd : m0_cmd;
        sel_wr    = sel ? m1_wr_data : m0_wr_data;
    end

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            rr_next     <= 1'b0;
            idle_cnt    <= '0;
            i2c_req     <= 1'b0;
            i2c_cmd     <= '0;
            i2c_wr_data <= '0;
            m0_grant    <= 1'b0;
            m1_grant    <= 1'b0;
            m0_done     <= 1'b0;
            m1_done     <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rd_data  <= '0;
            m1_rd_data  <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            i2c_req     <= 1'b0;
            m0_done     <= 1'b0;
            m1_done     <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        state       <= ST_ISSUE;
                        owner       <= sel;
                        m0_grant    <= ~sel;
                        m1_grant    <= sel;
                        i2c_req     <= 1'b1;
                        i2c_cmd     <= sel_cmd;
                        i2c_wr_data <= sel_wr;
                        busy        <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (i2c_done) begin
                        state <= ST_DONE;
                        if (owner) begin
                            m1_done    <= 1'b1;
                            m1_rd_data <= i2c_rd_data;
                            m1_ack     <= i2c_slave_ack;
                        end else begin
                            m0_done    <= 1'b1;
                            m0_rd_data <= i2c_rd_data;
                            m0_ack     <= i2c_slave_ack;
                        end
                    end
                end
                ST_DONE: begin
                    if (i2c_cmd[3]) begin
                        state    <= ST_IDLE;
                        m0_grant <= 1'b0;
                        m1_grant <= 1'b0;
                        busy     <= 1'b0;
                        rr_next  <= ~owner;
                    end else begin
                        state    <= ST_OWN;
                        idle_cnt <= '0;
                    end
                end
                ST_OWN: begin
                    if (owner_req) begin
                        state       <= ST_ISSUE;
                        i2c_req     <= 1'b1;
                        i2c_cmd     <= sel_cmd;
                        i2c_wr_data <= sel_wr;
                    end else if (idle_cnt == CNT_TRIP) begin
                        state       <= ST_IDLE;
                        timeout_err <= 1'b1;
                        m0_grant    <= 1'b0;
                        m1_grant    <= 1'b0;
                        busy        <= 1'b0;
                        rr_next     <= ~owner;
                        idle_cnt    <= idle_cnt + 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed self-checking bench for i2c_arbiter (TIMEOUT_CYC = 16).
module tb_i2c_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m1_req;
    logic [3:0] m0_cmd, m1_cmd;
    logic [7:0] m0_wr_data, m1_wr_data;
    logic [7:0] m0_rd_data, m1_rd_data;
    logic       m0_done, m1_done, m0_ack, m1_ack, m0_grant, m1_grant;
    logic       i2c_req;
    logic [3:0] i2c_cmd;
    logic [7:0] i2c_wr_data;
    logic [7:0] i2c_rd_data;
    logic       i2c_done, i2c_slave_ack;
    logic       busy, timeout_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_wr_data(m0_wr_data),
        .m0_rd_data(m0_rd_data), .m0_done(m0_done), .m0_ack(m0_ack), .m0_grant(m0_grant),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_wr_data(m1_wr_data),
        .m1_rd_data(m1_rd_data), .m1_done(m1_done), .m1_ack(m1_ack), .m1_grant(m1_grant),
        .i2c_req(i2c_req), .i2c_cmd(i2c_cmd), .i2c_wr_data(i2c_wr_data),
        .i2c_rd_data(i2c_rd_data), .i2c_done(i2c_done), .i2c_slave_ack(i2c_slave_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at the negedge of the cycle in which the requester's req is sampled.
    // Returns at the negedge of the DONE cycle with that requester's req dropped.
    task automatic xfer(input string tag, input logic who, input logic [3:0] ecmd,
                        input logic [7:0] ewr, input logic [7:0] rd, input logic ack);
        step();
        chk({tag, "_grant"}, 32'(who ? m1_grant : m0_grant), 1);
        chk({tag, "_other_grant"}, 32'(who ? m0_grant : m1_grant), 0);
        chk({tag, "_i2c_req"}, 32'(i2c_req), 1);
        chk({tag, "_cmd"}, 32'(i2c_cmd), 32'(ecmd));
        chk({tag, "_wr"}, 32'(i2c_wr_data), 32'(ewr));
        chk({tag, "_busy"}, 32'(busy), 1);
        step();
        chk({tag, "_i2c_req_wait"}, 32'(i2c_req), 0);
        chk({tag, "_cmd_hold"}, 32'(i2c_cmd), 32'(ecmd));
        i2c_done      = 1'b1;
        i2c_rd_data   = rd;
        i2c_slave_ack = ack;
        step();
        i2c_done = 1'b0;
        chk({tag, "_done"}, 32'(who ? m1_done : m0_done), 1);
        chk({tag, "_other_done"}, 32'(who ? m0_done : m1_done), 0);
        chk({tag, "_rd"}, 32'(who ? m1_rd_data : m0_rd_data), 32'(rd));
        chk({tag, "_ack"}, 32'(who ? m1_ack : m0_ack), 32'(ack));
        if (who) m1_req = 1'b0;
        else     m0_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b0; m0_cmd = '0; m0_wr_data = '0;
        m1_req = 1'b0; m1_cmd = '0; m1_wr_data = '0;
        i2c_rd_data = '0; i2c_done = 1'b0; i2c_slave_ack = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_m0_grant", 32'(m0_grant), 0);
        chk("rst_m1_grant", 32'(m1_grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_i2c_req", 32'(i2c_req), 0);
        chk("rst_i2c_cmd", 32'(i2c_cmd), 0);
        chk("rst_i2c_wr", 32'(i2c_wr_data), 0);
        chk("rst_m0_done", 32'(m0_done), 0);
        chk("rst_m1_rd", 32'(m1_rd_data), 0);
        chk("rst_timeout", 32'(timeout_err), 0);

        // Single locked transaction: START+WRITE 0x70, slave ACKs
        m0_req = 1'b1; m0_cmd = 4'b0011; m0_wr_data = 8'h70;
        xfer("s1", 1'b0, 4'h3, 8'h70, 8'hAA, 1'b1);
        step();
        chk("s1_own_done_low", 32'(m0_done), 0);
        chk("s1_own_grant", 32'(m0_grant), 1);
        chk("s1_own_busy", 32'(busy), 1);
        chk("s1_own_ack", 32'(m0_ack), 1);

        // Read with stop from OWN
        m0_req = 1'b1; m0_cmd = 4'b1100; m0_wr_data = 8'h00;
        xfer("s2", 1'b0, 4'hC, 8'h00, 8'h1C, 1'b0);
        chk("s2_done_grant", 32'(m0_grant), 1);
        step();
        chk("s2_rel_grant", 32'(m0_grant), 0);
        chk("s2_rel_busy", 32'(busy), 0);
        chk("s2_rel_rd_hold", 32'(m0_rd_data), 32'h1C);

        // Simultaneous requests after reset: m0, then m1, then alternating
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("s3_rst_rd", 32'(m0_rd_data), 0);
        m0_req = 1'b1; m0_cmd = 4'b1010; m0_wr_data = 8'h11;
        m1_req = 1'b1; m1_cmd = 4'b1110; m1_wr_data = 8'h22;
        xfer("s3a", 1'b0, 4'hA, 8'h11, 8'h55, 1'b1);
        chk("s3a_m1_rd_hold", 32'(m1_rd_data), 0);
        chk("s3a_m1_ack_hold", 32'(m1_ack), 0);
        step();
        chk("s3a_rel_m0", 32'(m0_grant), 0);
        chk("s3a_rel_m1", 32'(m1_grant), 0);
        xfer("s3b", 1'b1, 4'hE, 8'h22, 8'h66, 1'b1);
        chk("s3b_m0_rd_hold", 32'(m0_rd_data), 32'h55);
        step();
        m0_req = 1'b1; m1_req = 1'b1;
        xfer("s3c", 1'b0, 4'hA, 8'h11, 8'h01, 1'b1);
        step();
        xfer("s3d", 1'b1, 4'hE, 8'h22, 8'h02, 1'b0);
        step();
        m0_req = 1'b1; m1_req = 1'b1;
        xfer("s3e", 1'b0, 4'hA, 8'h11, 8'h03, 1'b1);
        step();
        xfer("s3f", 1'b1, 4'hE, 8'h22, 8'h04, 1'b1);
        step();

        // Lock stall: m1 waits while m0 holds the bus
        m0_req = 1'b1; m0_cmd = 4'b0001; m0_wr_data = 8'hA0;
        xfer("s4a", 1'b0, 4'h1, 8'hA0, 8'h00, 1'b1);
        m1_req = 1'b1; m1_cmd = 4'b1010; m1_wr_data = 8'h33;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("s4_stall_m1_grant", 32'(m1_grant), 0);
            chk("s4_stall_m1_done", 32'(m1_done), 0);
            chk("s4_stall_m0_grant", 32'(m0_grant), 1);
        end
        m0_req = 1'b1; m0_cmd = 4'b1000; m0_wr_data = 8'h00;
        xfer("s4b", 1'b0, 4'h8, 8'h00, 8'h00, 1'b1);
        step();
        chk("s4_idle_m1_grant", 32'(m1_grant), 0);
        xfer("s4c", 1'b1, 4'hA, 8'h33, 8'h77, 1'b0);
        step();

        // Timeout: m0 locked and idle, m1 pending
        m0_req = 1'b1; m0_cmd = 4'b0011; m0_wr_data = 8'h44;
        xfer("s5a", 1'b0, 4'h3, 8'h44, 8'h88, 1'b1);
        m1_req = 1'b1; m1_cmd = 4'b1010; m1_wr_data = 8'h99;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k < 16) begin
                chk("s5_pre_timeout", 32'(timeout_err), 0);
                chk("s5_pre_m0_grant", 32'(m0_grant), 1);
            end else begin
                chk("s5_timeout", 32'(timeout_err), 1);
                chk("s5_to_m0_grant", 32'(m0_grant), 0);
                chk("s5_to_m1_grant", 32'(m1_grant), 0);
                chk("s5_to_busy", 32'(busy), 0);
            end
        end
        xfer("s5b", 1'b1, 4'hA, 8'h99, 8'h12, 1'b1);
        chk("s5b_timeout_low", 32'(timeout_err), 0);
        step();

        // Reset during WAIT abandons the transfer
        m0_req = 1'b1; m0_cmd = 4'b0011; m0_wr_data = 8'h5A;
        step();
        chk("s6_issue_grant", 32'(m0_grant), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_req = 1'b0;
        i2c_done = 1'b1; i2c_rd_data = 8'hFF; i2c_slave_ack = 1'b1;
        chk("s6_rst_grant", 32'(m0_grant), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_cmd", 32'(i2c_cmd), 0);
        chk("s6_rst_wr", 32'(i2c_wr_data), 0);
        chk("s6_rst_rd", 32'(m0_rd_data), 0);
        chk("s6_rst_i2c_req", 32'(i2c_req), 0);
        step();
        i2c_done = 1'b0;
        chk("s6_no_done", 32'(m0_done), 0);
        chk("s6_no_rd", 32'(m0_rd_data), 0);
        chk("s6_no_ack", 32'(m0_ack), 0);
        chk("s6_idle_busy", 32'(busy), 0);
        step();
        chk("s6_no_done_late", 32'(m0_done), 0);
        chk("s6_no_grant_late", 32'(m0_grant), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
